// File: rtl/csi_uport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csi_uport_pkg
//  Description : Shared register map, response codes and FSM state types for
//                the CSI micro-port AXI4-Lite responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package csi_uport_pkg;

  // Identification word returned from the ID register by default
  localparam logic [31:0] c_ID_VALUE_DEFAULT = 32'h4353_4955;

  // Byte offsets of the register map
  localparam logic [7:0] c_OFF_ID       = 8'h00;
  localparam logic [7:0] c_OFF_CTRL     = 8'h04;
  localparam logic [7:0] c_OFF_STATUS   = 8'h08;
  localparam logic [7:0] c_OFF_SCRATCH  = 8'h0C;
  localparam logic [7:0] c_OFF_WR_COUNT = 8'h10;
  localparam logic [7:0] c_OFF_RD_COUNT = 8'h14;

  // Word indices as seen by the decoder (addr[7:2])
  localparam logic [5:0] c_IDX_ID       = c_OFF_ID[7:2];
  localparam logic [5:0] c_IDX_CTRL     = c_OFF_CTRL[7:2];
  localparam logic [5:0] c_IDX_STATUS   = c_OFF_STATUS[7:2];
  localparam logic [5:0] c_IDX_SCRATCH  = c_OFF_SCRATCH[7:2];
  localparam logic [5:0] c_IDX_WR_COUNT = c_OFF_WR_COUNT[7:2];
  localparam logic [5:0] c_IDX_RD_COUNT = c_OFF_RD_COUNT[7:2];

  // AXI response encodings
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  // Write and read channel state machines
  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // True for offsets that accept writes
  function automatic logic is_rw_index(input logic [5:0] idx);
    return (idx == c_IDX_CTRL) || (idx == c_IDX_SCRATCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi_uport_strb_merge.sv
`default_nettype none
// ============================================================================
//  Module      : csi_uport_strb_merge
//  Description : Byte-lane merge of a new word into an old word under a
//                4-bit write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module csi_uport_strb_merge
  import csi_uport_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_word,
  input  logic [3:0]  i_strb,
  output logic [31:0] o_merged_word
);

  // Each lane takes the new byte when its strobe bit is set
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign o_merged_word[8*g +: 8] = i_strb[g] ? i_new_word[8*g +: 8]
                                               : i_old_word[8*g +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/csi_uport_axil_responder.sv
`default_nettype none
// ============================================================================
//  Module      : csi_uport_axil_responder
//  Description : AXI4-Lite slave exposing ID, CTRL, STATUS, SCRATCH and
//                transaction counters. Independent read and write paths,
//                one outstanding transaction per direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module csi_uport_axil_responder
  import csi_uport_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = c_ID_VALUE_DEFAULT
) (
  input  logic                  ACLK_UPORT,
  input  logic                  ARESETN_UPORT,
  // write address
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  // write data
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  // write response
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  // read address
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  // read data
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  // register interface
  output logic [31:0]           ctrl_out,
  input  logic [31:0]           status_in
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic        r_live;

  w_state_t    r_wstate;
  w_state_t    w_wstate_next;
  logic        w_do_write;
  logic        r_aw_held;
  logic        r_w_held;
  logic [5:0]  r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic [31:0] w_merge_old;
  logic [31:0] w_merged;

  r_state_t    r_rstate;
  r_state_t    w_rstate_next;
  logic        w_ar_hs;
  logic [5:0]  w_ar_idx;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic [31:0] r_ctrl;
  logic [31:0] r_scratch;
  logic [31:0] r_wr_count;
  logic [31:0] r_rd_count;

  // Protection bits and address bits outside [7:2] carry no meaning here
  logic        w_unused;
  assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  // Keeps every ready low until the first clock edge after reset release
  always_ff @(posedge ACLK_UPORT or negedge ARESETN_UPORT) begin
    if (!ARESETN_UPORT) r_live <= 1'b0;
    else                r_live <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Write channel
  // --------------------------------------------------------------------------
  assign s_axil_awready = r_live && (r_wstate == W_IDLE) && !r_aw_held;
  assign s_axil_wready  = r_live && (r_wstate == W_IDLE) && !r_w_held;
  assign s_axil_bvalid  = (r_wstate == W_RESP);
  assign s_axil_bresp   = r_bresp;

  assign w_aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_w_hs  = s_axil_wvalid  && s_axil_wready;

  // Write state register
  always_ff @(posedge ACLK_UPORT or negedge ARESETN_UPORT) begin
    if (!ARESETN_UPORT) r_wstate <= W_IDLE;
    else                r_wstate <= w_wstate_next;
  end

  // Write next-state: commit once both halves are held, then wait for bready
  always_comb begin
    w_wstate_next = r_wstate;
    w_do_write    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (r_aw_held && r_w_held) begin
          w_do_write    = 1'b1;
          w_wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axil_bready) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Capture AW and W independently; both flags drop on the commit edge
  always_ff @(posedge ACLK_UPORT or negedge ARESETN_UPORT) begin
    if (!ARESETN_UPORT) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_do_write) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s_axil_awaddr[7:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end
    end
  end

  // Only CTRL and SCRATCH are writable, so the merge base is one of the two
  assign w_merge_old = (r_aw_idx == c_IDX_CTRL) ? r_ctrl : r_scratch;

  csi_uport_strb_merge u_strb_merge (
    .i_old_word    (w_merge_old),
    .i_new_word    (r_wdata),
    .i_strb        (r_wstrb),
    .o_merged_word (w_merged)
  );

  // Register update, response code and write counter on the commit edge
  always_ff @(posedge ACLK_UPORT or negedge ARESETN_UPORT) begin
    if (!ARESETN_UPORT) begin
      r_ctrl     <= '0;
      r_scratch  <= '0;
      r_wr_count <= '0;
      r_bresp    <= c_RESP_OKAY;
    end else if (w_do_write) begin
      r_wr_count <= r_wr_count + 32'd1;
      r_bresp    <= is_rw_index(r_aw_idx) ? c_RESP_OKAY : c_RESP_SLVERR;
      if (r_aw_idx == c_IDX_CTRL)    r_ctrl    <= w_merged;
      if (r_aw_idx == c_IDX_SCRATCH) r_scratch <= w_merged;
    end
  end

  assign ctrl_out = r_ctrl;

  // --------------------------------------------------------------------------
  // Read channel
  // --------------------------------------------------------------------------
  assign s_axil_arready = r_live && (r_rstate == R_IDLE);
  assign s_axil_rvalid  = (r_rstate == R_DATA);
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;

  assign w_ar_hs  = s_axil_arvalid && s_axil_arready;
  assign w_ar_idx = s_axil_araddr[7:2];

  // Read state register
  always_ff @(posedge ACLK_UPORT or negedge ARESETN_UPORT) begin
    if (!ARESETN_UPORT) r_rstate <= R_IDLE;
    else                r_rstate <= w_rstate_next;
  end

  // Read next-state: data phase after the AR handshake until rready
  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs)       w_rstate_next = R_DATA;
      R_DATA: if (s_axil_rready) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Read decode; register values are pre-update on a coincident write edge
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_RESP_OKAY;
    case (w_ar_idx)
      c_IDX_ID:       w_rd_data = ID_VALUE;
      c_IDX_CTRL:     w_rd_data = r_ctrl;
      c_IDX_STATUS:   w_rd_data = status_in;
      c_IDX_SCRATCH:  w_rd_data = r_scratch;
      c_IDX_WR_COUNT: w_rd_data = r_wr_count;
      c_IDX_RD_COUNT: w_rd_data = r_rd_count;
      default:        w_rd_resp = c_RESP_SLVERR;
    endcase
  end

  // Register read payload and count the AR handshake
  always_ff @(posedge ACLK_UPORT or negedge ARESETN_UPORT) begin
    if (!ARESETN_UPORT) begin
      r_rdata    <= '0;
      r_rresp    <= c_RESP_OKAY;
      r_rd_count <= '0;
    end else if (w_ar_hs) begin
      r_rdata    <= w_rd_data;
      r_rresp    <= w_rd_resp;
      r_rd_count <= r_rd_count + 32'd1;
    end
  end

endmodule
`default_nettype wire
